// File: rtl/timer_bcd_mmss.sv
// MM:SS BCD countdown/count-up timer with IDLE/RUN/PAUSE/DONE control.
// The count register holds packed BCD digits and feeds the display outputs directly.
module timer_bcd_mmss #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       load,
  input  logic       up_down,
  input  logic [3:0] set_M1,
  input  logic [3:0] set_M0,
  input  logic [3:0] set_S1,
  input  logic [3:0] set_S0,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } mmss_t;

  localparam logic [3:0] TERM_M1   = 4'(MAX_MIN / 10);
  localparam logic [3:0] TERM_M0   = 4'(MAX_MIN % 10);
  localparam logic [6:0] MAX_MIN_W = 7'(MAX_MIN);

  state_t state, state_next;
  mmss_t  cnt, cnt_next;
  logic   mode_up, mode_up_next;

  function automatic logic [6:0] minutes_of(input mmss_t c);
    return (7'(c.m1) * 7'd10) + 7'(c.m0);
  endfunction

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic mmss_t clamp_preset(input logic [3:0] m1, input logic [3:0] m0,
                                         input logic [3:0] s1, input logic [3:0] s0);
    mmss_t p;
    p.m1 = sat9(m1);
    p.m0 = sat9(m0);
    p.s1 = (s1 > 4'd5) ? 4'd5 : s1;
    p.s0 = sat9(s0);
    if (minutes_of(p) > MAX_MIN_W) begin
      p = '{m1: TERM_M1, m0: TERM_M0, s1: 4'd0, s0: 4'd0};
    end
    return p;
  endfunction

  // Down-count never starts from 00:00 in RUN, so the minutes-tens borrow cannot underflow.
  function automatic mmss_t step_down(input mmss_t c);
    mmss_t n;
    n = c;
    if (c.s0 != 4'd0) begin
      n.s0 = c.s0 - 4'd1;
    end else begin
      n.s0 = 4'd9;
      if (c.s1 != 4'd0) begin
        n.s1 = c.s1 - 4'd1;
      end else begin
        n.s1 = 4'd5;
        if (c.m0 != 4'd0) begin
          n.m0 = c.m0 - 4'd1;
        end else begin
          n.m0 = 4'd9;
          n.m1 = c.m1 - 4'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic mmss_t step_up(input mmss_t c);
    mmss_t n;
    n = c;
    if (c.s0 != 4'd9) begin
      n.s0 = c.s0 + 4'd1;
    end else begin
      n.s0 = 4'd0;
      if (c.s1 != 4'd5) begin
        n.s1 = c.s1 + 4'd1;
      end else begin
        n.s1 = 4'd0;
        if (c.m0 != 4'd9) begin
          n.m0 = c.m0 + 4'd1;
        end else begin
          n.m0 = 4'd0;
          n.m1 = c.m1 + 4'd1;
        end
      end
    end
    return n;
  endfunction

  // Up mode treats any value in the last minute as terminal so a preset such as
  // MAX_MIN:30 finishes instead of running past the limit.
  function automatic logic is_terminal(input mmss_t c, input logic up);
    if (up) return minutes_of(c) >= MAX_MIN_W;
    else    return c == '0;
  endfunction

  always_comb begin
    mmss_t stepped;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_next   = state;
    cnt_next     = cnt;
    mode_up_next = mode_up;
    stepped      = mode_up ? step_up(cnt) : step_down(cnt);

    if (load) begin
      cnt_next     = clamp_preset(set_M1, set_M0, set_S1, set_S0);
      mode_up_next = up_down;
      state_next   = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_stop) state_next = is_terminal(cnt, mode_up) ? DONE : RUN;
        end
        RUN: begin
          // A start_stop in the same cycle as a tick wins; that tick is dropped.
          if (start_stop) begin
            state_next = PAUSE;
          end else if (tick) begin
            cnt_next = stepped;
            if (is_terminal(stepped, mode_up)) state_next = DONE;
          end
        end
        PAUSE: begin
          if (start_stop) state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_up <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_next;
      cnt     <= cnt_next;
      mode_up <= mode_up_next;
      running <= (state_next == RUN);
      done    <= (state_next == DONE);
    end
  end

  assign BCD0 = cnt.s0;
  assign BCD1 = cnt.s1;
  assign BCD2 = cnt.m0;
  assign BCD3 = cnt.m1;

endmodule

// File: tb/tb_timer_bcd_mmss.sv
// Directed bench for timer_bcd_mmss (MAX_MIN = 59); inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
module tb_timer_bcd_mmss;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_stop;
  logic       load;
  logic       up_down;
  logic [3:0] set_M1, set_M0, set_S1, set_S0;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic       running;
  logic       done;

  int errors = 0;
  int checks = 0;

  timer_bcd_mmss #(.MAX_MIN(59)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .load       (load),
    .up_down    (up_down),
    .set_M1     (set_M1),
    .set_M0     (set_M0),
    .set_S1     (set_S1),
    .set_S0     (set_S0),
    .BCD0       (BCD0),
    .BCD1       (BCD1),
    .BCD2       (BCD2),
    .BCD3       (BCD3),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] cnt, input logic run, input logic dn);
    check({tag, " count"}, {BCD3, BCD2, BCD1, BCD0}, cnt);
    check({tag, " running"}, {15'd0, running}, {15'd0, run});
    check({tag, " done"}, {15'd0, done}, {15'd0, dn});
  endtask

  // Advance one clock; single-cycle pulses are cleared right after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    tick       = 1'b0;
    start_stop = 1'b0;
    load       = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] m1, input logic [3:0] m0,
                         input logic [3:0] s1, input logic [3:0] s0, input logic up);
    set_M1 = m1; set_M0 = m0; set_S1 = s1; set_S0 = s0;
    up_down = up;
    load = 1'b1;
    cycle();
  endtask

  task automatic do_start();
    start_stop = 1'b1;
    cycle();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start_stop = 1'b0; load = 1'b0; up_down = 1'b0;
    set_M1 = 4'd0; set_M0 = 4'd0; set_S1 = 4'd0; set_S0 = 4'd0;

    #2;
    check_all("reset_state", 16'h0000, 1'b0, 1'b0);
    #11;
    reset = 1'b1;
    cycle();
    check_all("after_release", 16'h0000, 1'b0, 1'b0);

    // 00:03 down, three ticks to done
    do_load(4'd0, 4'd0, 4'd0, 4'd3, 1'b0);
    check_all("load_0003", 16'h0003, 1'b0, 1'b0);
    do_tick();
    check("idle_tick_ignored", {BCD3, BCD2, BCD1, BCD0}, 16'h0003);
    do_start();
    check_all("start_0003", 16'h0003, 1'b1, 1'b0);
    do_tick();
    check_all("down_tick1", 16'h0002, 1'b1, 1'b0);
    do_tick();
    check_all("down_tick2", 16'h0001, 1'b1, 1'b0);
    do_tick();
    check_all("down_tick3", 16'h0000, 1'b0, 1'b1);
    do_tick();
    check_all("done_holds", 16'h0000, 1'b0, 1'b1);
    do_start();
    check_all("done_ignores_ss", 16'h0000, 1'b0, 1'b1);

    // 01:00 down -> 00:59
    do_load(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
    check_all("load_clears_done", 16'h0100, 1'b0, 1'b0);
    do_start();
    do_tick();
    check_all("borrow_0100", 16'h0059, 1'b1, 1'b0);

    // 10:00 down -> 09:59, full borrow chain
    do_load(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    do_start();
    do_tick();
    check("borrow_1000", {BCD3, BCD2, BCD1, BCD0}, 16'h0959);

    // 09:59 up -> 10:00, full carry chain
    do_load(4'd0, 4'd9, 4'd5, 4'd9, 1'b1);
    do_start();
    do_tick();
    check_all("carry_0959", 16'h1000, 1'b1, 1'b0);

    // Pause with start_stop + tick together at 00:10
    do_load(4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
    do_start();
    start_stop = 1'b1; tick = 1'b1;
    cycle();
    check_all("pause_tick_dropped", 16'h0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_tick();
    check_all("pause_holds", 16'h0010, 1'b0, 1'b0);
    do_start();
    check_all("resume", 16'h0010, 1'b1, 1'b0);
    do_tick();
    check("resume_tick", {BCD3, BCD2, BCD1, BCD0}, 16'h0009);

    // 58:59 up: one tick reaches 59:00 and finishes
    do_load(4'd5, 4'd8, 4'd5, 4'd9, 1'b1);
    do_start();
    do_tick();
    check_all("up_5859_to_term", 16'h5900, 1'b0, 1'b1);

    // 57:59 up: 61 ticks to 59:00, then held
    do_load(4'd5, 4'd7, 4'd5, 4'd9, 1'b1);
    do_start();
    for (int i = 0; i < 60; i++) do_tick();
    check_all("up_tick60", 16'h5859, 1'b1, 1'b0);
    do_tick();
    check_all("up_tick61", 16'h5900, 1'b0, 1'b1);
    do_tick();
    do_tick();
    check_all("up_no_wrap", 16'h5900, 1'b0, 1'b1);

    // Preset clamps
    do_load(4'hA, 4'd7, 4'd9, 4'hF, 1'b1);
    check_all("clamp_to_max", 16'h5900, 1'b0, 1'b0);
    do_start();
    check_all("idle_at_term_done", 16'h5900, 1'b0, 1'b1);
    do_load(4'd1, 4'hF, 4'd7, 4'd2, 1'b0);
    check("clamp_digits", {BCD3, BCD2, BCD1, BCD0}, 16'h1952);

    // Load and start_stop together: load wins
    set_M1 = 4'd0; set_M0 = 4'd0; set_S1 = 4'd0; set_S0 = 4'd5; up_down = 1'b0;
    load = 1'b1; start_stop = 1'b1;
    cycle();
    check_all("load_beats_ss", 16'h0005, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN at 12:34
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    do_start();
    check_all("run_1234", 16'h1234, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    cycle();
    do_tick();
    check_all("idle_after_reset", 16'h0000, 1'b0, 1'b0);
    do_start();
    check_all("reset_mode_down_done", 16'h0000, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
